// File: rtl/shot_if.sv
// Fire-control bundle between the ship input logic, the shot counter and the unlocked gate.
// The debug field state_dbg mirrors the counter FSM (1 = COOLDOWN).
interface shot_if;
  logic       fire_btn;
  logic       unlocked_signal;
  logic       missile_retire;
  logic       level_clear;
  logic [3:0] signal_counter;
  logic       fire_pulse;
  logic       cooldown_busy;
  logic       state_dbg;

  // Pulse protocol, no backpressure: missile_retire, level_clear and fire_pulse are
  // single-cycle strobes acted on at the pclk edge that samples them, with no
  // acknowledge. fire_btn and unlocked_signal are levels.
  modport master (
    output fire_btn, unlocked_signal, missile_retire, level_clear,
    input  signal_counter, fire_pulse, cooldown_busy, state_dbg
  );
  modport slave (
    input  fire_btn, unlocked_signal, missile_retire, level_clear,
    output signal_counter, fire_pulse, cooldown_busy, state_dbg
  );
endinterface

// File: rtl/shot_counter.sv
// Missile-in-flight counter with fire-button edge detect, post-shot cooldown,
// retire accounting and level-clear abort.
module shot_counter #(
  parameter int CD_CYCLES = 650000,
  parameter int CD_W      = 20,
  parameter int MAX_SHOTS = 15
) (
  input  logic   pclk,
  input  logic   rst_n,
  shot_if.slave  bus
);
  typedef enum logic {READY = 1'b0, COOLDOWN = 1'b1} state_t;

  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(CD_CYCLES - 1);
  localparam logic [3:0]      MAX_CNT = 4'(MAX_SHOTS);

  state_t          state, state_next;
  logic [CD_W-1:0] timer, timer_next;
  logic [3:0]      count, count_next;
  logic            btn_prev;
  logic            pulse, pulse_next;
  logic            rise, accept;

  always_comb begin
    rise       = bus.fire_btn & ~btn_prev;
    accept     = rise & bus.unlocked_signal & (state == READY) & ~bus.level_clear;
    state_next = state;
    timer_next = timer;
    pulse_next = accept;
    count_next = count;

    case (state)
      READY: begin
        if (accept) begin
          state_next = COOLDOWN;
          timer_next = CD_LOAD;
        end
      end
      COOLDOWN: begin
        if (timer == '0) state_next = READY;
        else             timer_next = timer - 1'b1;
      end
      default: state_next = READY;
    endcase

    // level_clear wins over everything, including an in-progress cooldown.
    if (bus.level_clear) begin
      state_next = READY;
      timer_next = '0;
    end

    if (bus.level_clear)
      count_next = '0;
    else if (accept && bus.missile_retire)
      count_next = count;
    else if (accept)
      count_next = (count < MAX_CNT) ? count + 1'b1 : MAX_CNT;
    else if (bus.missile_retire && count != 4'd0)
      count_next = count - 1'b1;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= READY;
      timer    <= '0;
      count    <= '0;
      btn_prev <= 1'b0;
      pulse    <= 1'b0;
    end else begin
      state    <= state_next;
      timer    <= timer_next;
      count    <= count_next;
      btn_prev <= bus.fire_btn;
      pulse    <= pulse_next;
    end
  end

  assign bus.signal_counter = count;
  assign bus.fire_pulse     = pulse;
  assign bus.cooldown_busy  = (state == COOLDOWN);
  assign bus.state_dbg      = (state == COOLDOWN);
endmodule

// File: tb/tb_shot_counter.sv
// Self-checking bench for shot_counter: vector table, directed corner sequences
// and randomized traffic against a remaining-cycles reference model.
module tb_shot_counter;
  localparam int CD = 4;

  logic pclk;
  logic rst_n;
  shot_if bus ();

  shot_counter #(.CD_CYCLES(CD), .CD_W(20), .MAX_SHOTS(15)) dut (
    .pclk  (pclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  int m_count;
  int m_left;     // busy cycles still to come after this edge
  bit m_pulse;
  bit m_prev;
  bit gate_q;     // unlocked gate: registered (count < 3)
  bit use_gate;

  task automatic model_reset();
    m_count = 0; m_left = 0; m_pulse = 0; m_prev = 0; gate_q = 1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("count", int'(bus.signal_counter), m_count);
    check("fire_pulse", int'(bus.fire_pulse), int'(m_pulse));
    check("busy", int'(bus.cooldown_busy), int'(m_left > 0));
    check("state_dbg", int'(bus.state_dbg), int'(m_left > 0));
  endtask

  // ---------------- driver ----------------
  // Apply inputs for one cycle, advance the model at the edge, check #1 later.
  task automatic cycle(input bit btn, input bit unl, input bit ret, input bit clr);
    bit u, rise, acc, gate_next;
    u = use_gate ? gate_q : unl;
    bus.fire_btn        = btn;
    bus.unlocked_signal = u;
    bus.missile_retire  = ret;
    bus.level_clear     = clr;
    @(posedge pclk);
    rise      = btn & ~m_prev;
    acc       = rise & u & (m_left == 0) & ~clr;
    gate_next = (m_count < 3);
    if (clr)             m_count = 0;
    else if (acc && ret) m_count = m_count;
    else if (acc)        m_count = (m_count < 15) ? m_count + 1 : 15;
    else if (ret && m_count > 0) m_count = m_count - 1;
    if (clr)             m_left = 0;
    else if (acc)        m_left = CD;
    else if (m_left > 0) m_left = m_left - 1;
    m_pulse = acc;
    m_prev  = btn;
    gate_q  = gate_next;
    #1;
    check_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 1, 0, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit btn; bit unl; bit ret; bit clr;
    int cnt; bit pulse; bit busy;
  } vec_t;
  vec_t vecs[18];

  initial begin
    bit pulse_seen;
    int pulses;
    int busy_cycles;

    //           btn unl ret clr  cnt pulse busy
    vecs[0]  = '{1, 1, 0, 0, 1, 1, 1};  // accept
    vecs[1]  = '{1, 1, 0, 0, 1, 0, 1};  // held: no second rise
    vecs[2]  = '{1, 1, 0, 0, 1, 0, 1};
    vecs[3]  = '{0, 1, 0, 0, 1, 0, 1};
    vecs[4]  = '{0, 1, 0, 0, 1, 0, 0};  // cooldown over after 4 cycles
    vecs[5]  = '{1, 1, 1, 0, 1, 1, 1};  // accept + retire: unchanged
    vecs[6]  = '{0, 1, 1, 0, 0, 0, 1};
    vecs[7]  = '{0, 1, 1, 0, 0, 0, 1};  // retire at 0 ignored
    vecs[8]  = '{1, 1, 0, 0, 0, 0, 1};  // rise in cooldown dropped
    vecs[9]  = '{0, 1, 0, 0, 0, 0, 0};
    vecs[10] = '{0, 1, 0, 0, 0, 0, 0};  // no queued shot
    vecs[11] = '{1, 0, 0, 0, 0, 0, 0};  // locked: dropped
    vecs[12] = '{0, 1, 0, 0, 0, 0, 0};
    vecs[13] = '{1, 1, 0, 1, 0, 0, 0};  // level_clear suppresses accept
    vecs[14] = '{0, 1, 0, 0, 0, 0, 0};
    vecs[15] = '{1, 1, 0, 0, 1, 1, 1};
    vecs[16] = '{0, 1, 0, 1, 0, 0, 0};  // clear aborts cooldown
    vecs[17] = '{1, 1, 0, 0, 1, 1, 1};  // immediately accepted again

    use_gate = 0;
    bus.fire_btn = 0; bus.unlocked_signal = 1; bus.missile_retire = 0; bus.level_clear = 0;
    rst_n = 0;
    model_reset();
    repeat (3) @(posedge pclk);
    #1;
    check("reset_count", int'(bus.signal_counter), 0);
    check("reset_pulse", int'(bus.fire_pulse), 0);
    check("reset_busy", int'(bus.cooldown_busy), 0);
    rst_n = 1;

    // -------- table-driven vectors --------
    for (int i = 0; i < 18; i++) begin
      cycle(vecs[i].btn, vecs[i].unl, vecs[i].ret, vecs[i].clr);
      check($sformatf("vec%0d_count", i), int'(bus.signal_counter), vecs[i].cnt);
      check($sformatf("vec%0d_pulse", i), int'(bus.fire_pulse), int'(vecs[i].pulse));
      check($sformatf("vec%0d_busy", i), int'(bus.cooldown_busy), int'(vecs[i].busy));
    end
    cycle(0, 1, 0, 1);
    idle(6);

    // -------- reset mid-cooldown --------
    cycle(1, 1, 0, 0);
    cycle(0, 1, 0, 0);
    rst_n = 0;
    #2;
    check("async_rst_count", int'(bus.signal_counter), 0);
    check("async_rst_busy", int'(bus.cooldown_busy), 0);
    check("async_rst_pulse", int'(bus.fire_pulse), 0);
    model_reset();
    @(posedge pclk);
    #1;
    rst_n = 1;
    cycle(0, 1, 0, 0);
    cycle(1, 1, 0, 0);
    check("post_rst_fire", int'(bus.fire_pulse), 1);
    cycle(0, 1, 0, 1);
    idle(2);

    // -------- gate-driven sequences --------
    use_gate = 1;
    // single press held 20 cycles
    pulses = 0; busy_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1, 1, 0, 0);
      pulses += int'(bus.fire_pulse);
      busy_cycles += int'(bus.cooldown_busy);
    end
    check("held_pulses", pulses, 1);
    check("held_busy_cycles", busy_cycles, CD);
    check("held_count", int'(bus.signal_counter), 1);
    cycle(0, 1, 0, 0);
    idle(4);
    // presses spaced 10 cycles: 2, 3, then locked at 3
    for (int p = 0; p < 3; p++) begin
      pulse_seen = 0;
      cycle(1, 1, 0, 0);
      pulse_seen = bus.fire_pulse;
      check($sformatf("press%0d_pulse", p), int'(pulse_seen), (p < 2) ? 1 : 0);
      for (int i = 0; i < 9; i++) cycle(0, 1, 0, 0);
    end
    check("locked_count", int'(bus.signal_counter), 3);
    cycle(0, 1, 1, 0);
    check("retire_count", int'(bus.signal_counter), 2);
    idle(2);
    cycle(1, 1, 0, 0);
    check("reaccept_count", int'(bus.signal_counter), 3);
    idle(6);
    // accept + retire at count 2
    cycle(0, 1, 1, 0);
    idle(2);
    cycle(1, 1, 1, 0);
    check("acc_ret_pulse", int'(bus.fire_pulse), 1);
    check("acc_ret_count", int'(bus.signal_counter), 2);
    // level_clear coincident with rise during cooldown
    cycle(0, 1, 0, 0);
    cycle(1, 1, 0, 1);
    check("clr_count", int'(bus.signal_counter), 0);
    check("clr_busy", int'(bus.cooldown_busy), 0);
    check("clr_pulse", int'(bus.fire_pulse), 0);
    cycle(0, 1, 0, 0);
    cycle(1, 1, 0, 0);
    check("after_clr_pulse", int'(bus.fire_pulse), 1);
    use_gate = 0;
    idle(6);

    // -------- saturation at 15 --------
    for (int p = 0; p < 17; p++) begin
      cycle(1, 1, 0, 0);
      for (int i = 0; i < CD + 1; i++) cycle(0, 1, 0, 0);
    end
    check("saturate_count", int'(bus.signal_counter), 15);
    cycle(0, 1, 0, 1);
    idle(2);

    // -------- randomized traffic --------
    for (int i = 0; i < 3000; i++) begin
      bit b;
      b = ($urandom_range(0, 9) < 4) ? ~m_prev : m_prev;
      cycle(b, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2,
            $urandom_range(0, 99) < 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, expected end of test");
    $fatal(1, "watchdog");
  end
endmodule
